// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the MMIO UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  localparam logic [31:0] UART_DATA_OFS   = 32'd0;
  localparam logic [31:0] UART_STATUS_OFS = 32'd1;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers for full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - store-port UART transmitter: register decode plus 8N1 serializer
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLOCK_DIVIDE = 1,
  parameter int          DEPTH        = 8,
  parameter logic [31:0] BASE         = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_enable,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        irq
);
  localparam int          DW          = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam int          CW          = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLOCK_DIVIDE - 1);
  localparam logic [31:0] DATA_ADDR   = BASE + UART_DATA_OFS;
  localparam logic [31:0] STATUS_ADDR = BASE + UART_STATUS_OFS;

  uart_tx_state_t state;
  logic [DW-1:0]  div_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           overflow;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     fifo_data;
  logic           data_wr;
  logic           push_ok;
  logic           ovf_clr;
  logic           bit_done;
  logic           pop;
  logic           unused_write_bits;

  assign data_wr  = write_enable && (addr == DATA_ADDR);
  assign ovf_clr  = write_enable && (addr == STATUS_ADDR) && write_data[ST_OVF];
  assign bit_done = (div_cnt == DIV_LAST);
  // Pop on the last stop cycle so consecutive frames abut with no idle bit.
  assign pop      = !fifo_empty && ((state == TX_IDLE) || ((state == TX_STOP) && bit_done));
  assign push_ok  = data_wr && (!fifo_full || pop);
  assign unused_write_bits = ^write_data[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data (write_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (pop) begin
            state   <= TX_START;
            shift   <= fifo_data;
            div_cnt <= '0;
          end
        end
        TX_START: begin
          if (bit_done) begin
            state   <= TX_DATA;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            div_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) state <= TX_STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        TX_STOP: begin
          if (bit_done) begin
            div_cnt <= '0;
            if (pop) begin
              state <= TX_START;
              shift <= fifo_data;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  // A dropped push in the same cycle as a clear leaves overflow set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  overflow <= 1'b0;
    else if (data_wr && !push_ok) overflow <= 1'b1;
    else if (ovf_clr)            overflow <= 1'b0;
  end

  always_comb begin
    tx = 1'b1;
    if (state == TX_START)     tx = 1'b0;
    else if (state == TX_DATA) tx = shift[0];
  end

  assign irq = fifo_empty && (state == TX_IDLE);

  always_comb begin
    read_data = '0;
    if (addr == STATUS_ADDR) begin
      read_data[ST_BUSY]           = (state != TX_IDLE);
      read_data[ST_FULL]           = fifo_full;
      read_data[ST_EMPTY]          = fifo_empty;
      read_data[ST_OVF]            = overflow;
      read_data[ST_COUNT_LSB +: 8] = 8'(fifo_count);
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
  localparam int          CD   = 4;
  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam logic [31:0] STAT = 32'hF000_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_tx_mmio #(
    .CLOCK_DIVIDE (CD),
    .DEPTH        (8),
    .BASE         (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .tx           (tx),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    write_enable = 1'b1;
    addr         = a;
    write_data   = d;
    tick(1);
    write_enable = 1'b0;
    addr         = '0;
    write_data   = '0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v    = read_data;
    addr = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    read_reg(STAT, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL reset_status got %h expected %h", v, 32'h4); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", tx); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq got %b expected 1", irq); end
    read_reg(BASE, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL data_read got %h expected 0", v); end
  endtask

  task automatic test_single_frame;
    logic [31:0] v;
    logic [9:0]  exp_bits;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    do_write(BASE, 32'h0000_00A5);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_before_pop got %b expected 1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_push got %b expected 0", irq); end
    read_reg(STAT, v);
    checks++; if (v !== 32'h100) begin errors++; $display("FAIL status_one_queued got %h expected %h", v, 32'h100); end
    tick(1);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_fall got %b expected 0", tx); end
    tick(2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx !== exp_bits[i]) begin errors++; $display("FAIL frame_bit%0d got %b expected %b", i, tx, exp_bits[i]); end
      if (i < 9) tick(CD);
    end
    tick(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_last_stop got %b expected 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_frame_end got %b expected 1", irq); end
    read_reg(STAT, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL status_frame_end got %h expected %h", v, 32'h4); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [29:0] stream;
    stream = {1'b1, 8'h5A, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 8'h3C, 1'b0};
    do_write(BASE, 32'h3C);
    do_write(BASE, 32'h81);
    do_write(BASE, 32'h5A);
    read_reg(STAT, v);
    checks++; if (v !== 32'h0201) begin errors++; $display("FAIL status_b2b got %h expected %h", v, 32'h0201); end
    for (int c = 1; c < 30 * CD; c++) begin
      checks++;
      if (tx !== stream[c / CD]) begin errors++; $display("FAIL b2b_cycle%0d got %b expected %b", c, tx, stream[c / CD]); end
      tick(1);
    end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle_tx got %b expected 1", tx); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL b2b_irq got %b expected 1", irq); end
    read_reg(STAT, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL b2b_status_end got %h expected %h", v, 32'h4); end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    int          n;
    for (int i = 0; i < 10; i++) do_write(BASE, 32'h10 + i);
    read_reg(STAT, v);
    checks++; if (v !== 32'h080B) begin errors++; $display("FAIL ovf_status got %h expected %h", v, 32'h080B); end
    do_write(BASE, 32'h41);
    read_reg(STAT, v);
    checks++; if (v !== 32'h080B) begin errors++; $display("FAIL ovf_sticky got %h expected %h", v, 32'h080B); end
    do_write(STAT, 32'h0);
    read_reg(STAT, v);
    checks++; if (v !== 32'h080B) begin errors++; $display("FAIL ovf_noclear got %h expected %h", v, 32'h080B); end
    do_write(STAT, 32'h8);
    read_reg(STAT, v);
    checks++; if (v !== 32'h0803) begin errors++; $display("FAIL ovf_clear got %h expected %h", v, 32'h0803); end
    n = 0;
    while (irq !== 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    checks++; if (n !== 349) begin errors++; $display("FAIL drain_cycles got %0d expected %0d", n, 349); end
    read_reg(STAT, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL drain_status got %h expected %h", v, 32'h4); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    int          bad;
    do_write(BASE, 32'h55);
    do_write(BASE, 32'h66);
    tick(18);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got %b expected 0", tx); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx got %b expected 1", tx); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL async_reset_irq got %b expected 1", irq); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    read_reg(STAT, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL post_reset_status got %h expected %h", v, 32'h4); end
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx !== 1'b1) bad++;
      tick(1);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL post_reset_quiet got %0d low cycles expected 0", bad); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped, buffered UART transmitter sitting downstream of the data memory's store port: the data-memory write path (`write_enable`/`addr`/`write_data`) drives it directly, and it produces the serial `tx` line. Stores to the DATA register queue bytes in a FIFO so software need not poll per byte. A serializer drains the FIFO as 8N1 frames. A STATUS register exposes busy, full, empty, overflow and fill level.

## Interface
- `CLOCK_DIVIDE`, 1 — clock cycles per serial bit, ≥1.
- `DEPTH`, 8 — FIFO entries, power of two, ≥2.
- `BASE`, 32'hF000_0000 — word address of DATA; STATUS is at BASE+1.
- `clk`  in  1 — sole clock, all state on rising edge.
- `rst_n`  in  1 — reset, asynchronous, active-low.
- `write_enable`  in  1 — store strobe from the data-memory write path.
- `addr`  in  32 — store/load address.
- `write_data`  in  32 — store data.
- `read_data`  out  32 — combinational register read for `addr`.
- `tx`  out  1 — serial output, idle high.
- `irq`  out  1 — level: FIFO empty and serializer idle.

## Operation
- DATA write (`write_enable` & `addr==BASE`): push `write_data[7:0]`. Accepted if FIFO not full, or if a pop occurs in the same cycle (count unchanged). Otherwise the byte is dropped and sticky `overflow` is set.
- STATUS write (`addr==BASE+1`): `write_data[3]==1` clears `overflow`. Other bits are ignored.
- Writes to any other address are ignored.
- STATUS read value:
  - bit0 busy: serializer not IDLE.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow.
  - bits[15:8] count, 0..DEPTH.
  - Other bits 0.
- DATA read and any other address return 0.
- Serializer FSM states IDLE, START, DATA, STOP. A bit counter tracks DATA bits 0..7; a divide counter runs 0..CLOCK_DIVIDE-1.
  - IDLE: `tx`=1. If FIFO non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for CLOCK_DIVIDE cycles, then DATA.
  - DATA: `tx`=shift[0], LSB first. Each bit is held CLOCK_DIVIDE cycles. Go to STOP after bit 7.
  - STOP: `tx`=1 for CLOCK_DIVIDE cycles. On the last stop cycle, if the FIFO is non-empty, pop and go to START (no idle gap); otherwise go to IDLE.
- If `overflow` set and clear occur in the same cycle, set wins.

## Timing
- Reset values: `tx`=1, FSM IDLE, FIFO empty (count 0), `overflow`=0, `irq`=1, shift register 0.
- `read_data` has zero latency (combinational from `addr` and current state).
- Push at edge N: STATUS shows empty=0 after N. The serializer pops at edge N+1, and `tx` falls after N+1.
- Frame length is exactly 10×CLOCK_DIVIDE cycles. Back-to-back frames have no idle cycle between them.
- `irq` deasserts the cycle after the first push. It reasserts in the cycle after the last stop bit completes with the FIFO empty.
- FIFO pointers use log2(DEPTH)+1 bits. Full: MSBs differ and the low bits are equal. Empty: pointers equal. Wrap-around is natural modulo 2·DEPTH.
- `rst_n` assertion mid-frame aborts the frame immediately: `tx`=1 asynchronously and all queued bytes are discarded.

## Structure
- Package `uart_pkg`:
  - FSM state enum `uart_tx_state_t`.
  - Register offsets `UART_DATA_OFS`=0 and `UART_STATUS_OFS`=1.
  - STATUS bit indices `ST_BUSY`, `ST_FULL`, `ST_EMPTY`, `ST_OVF`, `ST_COUNT_LSB`=8.
- Sub-module `sync_fifo`: parameterised by WIDTH and DEPTH, with push/pop/full/empty/count. The top level holds the register decode and the serializer FSM.

## Test plan
- Reset, then read STATUS → 0x0000_0004 (empty only); `tx`=1; `irq`=1.
- CLOCK_DIVIDE=4: write 0xA5 to BASE → `tx` falls 2 edges after the write. Sampled mid-bit it reads 0,1,0,1,0,0,1,0,1,1. Frame lasts 40 cycles; `irq` returns high afterwards.
- Write 3 bytes on consecutive cycles → STATUS count climbs 1, 2 then settles, with no idle high gap between stop and start. 30×CLOCK_DIVIDE cycles after the first start, `tx` is idle.
- DEPTH=8, CLOCK_DIVIDE=16: write 10 bytes back-to-back → 9 accepted (one popped at the second edge), 1 dropped. STATUS shows overflow=1 and full=1. Writing 0x8 to BASE+1 clears bit3.
- Write 0x41 to BASE at the same edge as an overflow-causing push while clearing → overflow remains 1 (set wins).
- Assert `rst_n` low mid DATA bit 3 → `tx`=1 immediately. After release: STATUS 0x0000_0004 and no further frame is emitted.
